// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and default sizing for the arbitrated mux
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEF_N = 8;
    localparam int DEF_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority / round-robin grant search over N requests
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          mode,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx
);

    logic [SW-1:0] base;
    logic [SW:0]   pos;
    logic          found;

    assign base = (mode_e'(mode) == MODE_RR) ? ptr : '0;

    // Walk upward from base, wrapping at N; the first set request wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, base} + (SW+1)'(i);
            if (pos >= (SW+1)'(N)) begin
                pos = pos - (SW+1)'(N);
            end
            if (!found && req[pos[SW-1:0]]) begin
                found = 1'b1;
                idx   = pos[SW-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-to-1 arbitrated mux with a single registered output stage
module arb_mux
    import mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [N-1:0]  in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]  in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_sel
);

    logic [W-1:0]  ch_data [N];
    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_next;
    logic          load;
    logic          en;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            ch_data[k] = in_data[k*W +: W];
        end
    end

    assign load = (!out_valid || out_ready) && (|in_valid);
    // Grants are suppressed during reset so no upstream word is consumed.
    assign en   = load && rst_n;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arbiter (
        .req   (in_valid),
        .ptr   (ptr),
        .mode  (mode),
        .en    (en),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign in_ready = grant;
    assign ptr_next = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt_idx];
            out_sel   <= gnt_idx;
            if (mode_e'(mode) == MODE_RR) begin
                ptr <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// tb/tb_arb_mux.sv - randomized and directed self-checking bench for arb_mux
module tb_arb_mux;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           mode = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;

    int total = 0;
    int bad   = 0;

    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_sel;
    int            m_ptr;
    logic [SW+W-1:0] sb[$];

    arb_mux #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grant(input logic [N-1:0] req, input int base);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (base + i) % N;
            if (req[k[SW-1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = '0;
        m_ptr   = 0;
        sb.delete();
    endtask

    // Entered just after a rising edge with inputs already applied; leaves 1 time unit after the next edge.
    task automatic cycle();
        logic [N-1:0]  er;
        logic          ld;
        int            g;
        logic          ov;
        logic [W-1:0]  od;
        logic [SW-1:0] os;
        logic [SW+W-1:0] front;
        ld = (!m_valid || out_ready) && (in_valid != '0);
        g  = ref_grant(in_valid, mode ? m_ptr : 0);
        er = '0;
        if (ld) er[g[SW-1:0]] = 1'b1;
        #1;
        check("in_ready", in_ready, er);
        ov = out_valid;
        od = out_data;
        os = out_sel;
        @(posedge clk);
        if (ov && out_ready) begin
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                front = sb.pop_front();
                check("sb_word", {os, od}, front);
            end
        end
        if (ld) begin
            m_data  = W'(in_data >> (g * W));
            m_sel   = g[SW-1:0];
            m_valid = 1'b1;
            sb.push_back({m_sel, m_data});
            if (mode) m_ptr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_sel", out_sel, m_sel);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sel", out_sel, 0);
        check("rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'h30 + 8'(k);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Fixed priority picks channel 2 from 1010_0100 every cycle.
        mode     = 1'b0;
        in_valid = 8'b1010_0100;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("fixed_sel", out_sel, 2);
        end

        // Round robin with all requesting walks 0..7 and wraps.
        do_reset();
        mode     = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("rr_seq", out_sel, i % N);
        end

        // Backpressure holding sel 3, then resume to 4.
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        check("bp_start", out_sel, 3);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_sel", out_sel, 3);
            check("bp_data", out_data, 8'h33);
            check("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_resume", out_sel, 4);

        // Single requester on channel 7, ptr back to 0 afterwards.
        do_reset();
        in_valid = 8'h80;
        in_data[63:56] = 8'hA5;
        #1;
        check("single_ready", in_ready, 8'h80);
        cycle();
        check("single_data", out_data, 8'hA5);
        check("single_sel", out_sel, 7);
        in_valid = 8'hFF;
        #1;
        check("single_ptr", in_ready, 8'h01);
        cycle();

        // Asynchronous reset between edges while holding a word.
        check("async_pre", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_data", out_data, 0);
        check("async_sel", out_sel, 0);
        check("async_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("async_hold", in_ready, 0);
        rst_n = 1'b1;
        model_reset();

        // Random valid/ready stress against the model and scoreboard.
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) mode = 1'($urandom);
            in_valid  = ($urandom % 5 == 0) ? '0 : N'($urandom & $urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom % 4) != 0;
            cycle();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
